// File: rtl/latealu_pkg.sv
// rtl/latealu_pkg.sv - opcodes, request layout and writeback states for the late-ALU issue controller
package latealu_pkg;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_SRL  = 6'd2;
  localparam logic [5:0] OP_SRA  = 6'd3;
  localparam logic [5:0] OP_MULT = 6'd4;
  localparam logic [5:0] OP_MTHI = 6'd5;
  localparam logic [5:0] OP_MTLO = 6'd6;
  localparam logic [5:0] OP_MFHI = 6'd7;
  localparam logic [5:0] OP_MFLO = 6'd8;

  localparam int REQ_W = 75;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [4:0]  dst;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAP_ALU = 2'd1,
    ST_CAP_HI  = 2'd2,
    ST_CAP_LO  = 2'd3
  } wb_state_e;

endpackage

// File: rtl/latealu_req_fifo.sv
// rtl/latealu_req_fifo.sv - 2-entry request FIFO with flush, full and empty flags
module latealu_req_fifo
  import latealu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [REQ_W-1:0] wdata,
  output logic [REQ_W-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [REQ_W-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  // Payload needs no reset: it is only observed while count says it is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pipeline_latealu_ctl.sv
// rtl/pipeline_latealu_ctl.sv - late-ALU issue controller: request buffering, HI/LO hazard stall, writeback capture
module pipeline_latealu_ctl
  import latealu_pkg::*;
#(
  parameter int MULT_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [31:0] in_a0,
  input  logic [31:0] in_a1,
  input  logic [4:0]  in_dst,
  output logic [5:0]  alu_op,
  output logic [31:0] alu_a0,
  output logic [31:0] alu_a1,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_hi,
  input  logic [31:0] alu_lo,
  output logic        wb_valid,
  output logic [4:0]  wb_dst,
  output logic [31:0] wb_data
);

  req_t      in_req;
  req_t      head;
  logic      full;
  logic      empty;
  logic      head_is_mf;
  logic      head_is_hilo_wr;
  logic      issue;
  logic [2:0] hilo_cnt;
  logic [4:0] cap_dst;
  wb_state_e state;
  wb_state_e state_nxt;

  assign in_req = {in_op, in_a0, in_a1, in_dst};

  latealu_req_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (in_valid & ~full),
    .pop   (issue),
    .wdata (in_req),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign in_ready        = ~full;
  assign head_is_mf      = (head.op == OP_MFHI) || (head.op == OP_MFLO);
  assign head_is_hilo_wr = (head.op == OP_MULT) || (head.op == OP_MTHI) || (head.op == OP_MTLO);
  // Unknown opcodes still pop here; they simply never reach the ALU or writeback.
  assign issue           = ~empty & ~flush & ~(head_is_mf & (hilo_cnt != 3'd0));

  always_comb begin
    alu_op = OP_NOP;
    if (issue && head.op >= OP_SRL && head.op <= OP_MTLO) alu_op = head.op;
  end

  assign alu_a0 = empty ? 32'd0 : head.a0;
  assign alu_a1 = empty ? 32'd0 : head.a1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hilo_cnt <= 3'd0;
    end else if (issue && head_is_hilo_wr) begin
      hilo_cnt <= 3'(MULT_LAT - 1);
    end else if (hilo_cnt != 3'd0) begin
      hilo_cnt <= hilo_cnt - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cap_dst <= 5'd0;
    end else begin
      state <= state_nxt;
      if (issue) cap_dst <= head.dst;
    end
  end

  // The next capture depends only on what issues now, so CAP states chain back to back.
  always_comb begin
    state_nxt = ST_IDLE;
    if (issue) begin
      case (head.op)
        OP_SRL, OP_SRA: state_nxt = ST_CAP_ALU;
        OP_MFHI:        state_nxt = ST_CAP_HI;
        OP_MFLO:        state_nxt = ST_CAP_LO;
        default:        state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_dst   <= 5'd0;
      wb_data  <= 32'd0;
    end else begin
      wb_valid <= (state != ST_IDLE);
      case (state)
        ST_CAP_ALU: begin
          wb_dst  <= cap_dst;
          wb_data <= alu_result;
        end
        ST_CAP_HI: begin
          wb_dst  <= cap_dst;
          wb_data <= alu_hi;
        end
        ST_CAP_LO: begin
          wb_dst  <= cap_dst;
          wb_data <= alu_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_latealu_ctl.sv
// tb/tb_pipeline_latealu_ctl.sv - directed scoreboard bench for pipeline_latealu_ctl with a behavioural late ALU
module tb_pipeline_latealu_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_op = 6'd0;
  logic [31:0] in_a0 = 32'd0;
  logic [31:0] in_a1 = 32'd0;
  logic [4:0]  in_dst = 5'd0;
  logic [5:0]  alu_op;
  logic [31:0] alu_a0;
  logic [31:0] alu_a1;
  logic [31:0] m_res = 32'd0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic        wb_valid;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int mult_cyc = 0;
  int n0;
  logic [36:0] sb[$];
  int wb_cycs[$];

  pipeline_latealu_ctl #(.MULT_LAT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a0      (in_a0),
    .in_a1      (in_a1),
    .in_dst     (in_dst),
    .alu_op     (alu_op),
    .alu_a0     (alu_a0),
    .alu_a1     (alu_a1),
    .alu_result (m_res),
    .alu_hi     (m_hi),
    .alu_lo     (m_lo),
    .wb_valid   (wb_valid),
    .wb_dst     (wb_dst),
    .wb_data    (wb_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Late ALU: registered results latched on the issue edge.
  always_ff @(posedge clk) begin
    case (alu_op)
      6'd2: m_res <= alu_a0 >> alu_a1[4:0];
      6'd3: m_res <= $unsigned($signed(alu_a0) >>> alu_a1[4:0]);
      6'd4: {m_hi, m_lo} <= 64'($signed(alu_a0)) * 64'($signed(alu_a1));
      6'd5: m_hi <= alu_a0;
      6'd6: m_lo <= alu_a0;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && alu_op == 6'd4) mult_cyc = cyc;
    if (rst && wb_valid) begin
      wb_cycs.push_back(cyc);
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL wb_unexpected observed dst=%0d data=%0h expected=no writeback", wb_dst, wb_data);
      end
      if (sb.size() != 0) check("wb_dst_data", 64'({wb_dst, wb_data}), 64'(sb.pop_front()));
    end
  end

  task automatic send(input logic [5:0] op, input logic [31:0] a0, input logic [31:0] a1, input logic [4:0] dst);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_op = op;
    in_a0 = a0;
    in_a1 = a1;
    in_dst = dst;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    check("accept_within_budget", 64'(ok), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_wb_valid", 64'(wb_valid), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_alu_op", 64'(alu_op), 64'(0));
    check("reset_wb_dst", 64'(wb_dst), 64'(0));
    check("reset_wb_data", 64'(wb_data), 64'(0));
    @(posedge clk);
    #1 rst = 1'b1;

    // Reset lands while the srl capture is pending: its writeback must vanish.
    send(6'd2, 32'hFFFF0000, 32'd8, 5'd7);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midreset_wb_valid", 64'(wb_valid), 64'(0));
    check("midreset_in_ready", 64'(in_ready), 64'(1));
    check("midreset_alu_op", 64'(alu_op), 64'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    tick(2);

    sb.push_back({5'd3, 32'h08000000});
    send(6'd2, 32'h80000000, 32'd4, 5'd3);
    in_valid = 1'b0;
    @(negedge clk);
    check("srl_alu_op", 64'(alu_op), 64'(2));
    check("srl_wb_edge0", 64'(wb_valid), 64'(0));
    @(negedge clk);
    check("srl_wb_edge1", 64'(wb_valid), 64'(0));
    @(negedge clk);
    check("srl_wb_edge2", 64'(wb_valid), 64'(1));
    tick(2);

    n0 = wb_cycs.size();
    sb.push_back({5'd10, 32'hF8000000});
    sb.push_back({5'd11, 32'h0000000F});
    send(6'd3, 32'h80000000, 32'd4, 5'd10);
    send(6'd2, 32'h000000F0, 32'd4, 5'd11);
    in_valid = 1'b0;
    tick(5);
    check("b2b_wb_count", 64'(wb_cycs.size() - n0), 64'(2));
    if (wb_cycs.size() >= n0 + 2) check("b2b_consecutive", 64'(wb_cycs[n0+1] - wb_cycs[n0]), 64'(1));

    n0 = wb_cycs.size();
    sb.push_back({5'd5, 32'hFFFFFFFF});
    sb.push_back({5'd6, 32'hFFFFFFFA});
    send(6'd4, 32'hFFFFFFFE, 32'd3, 5'd0);
    send(6'd7, 32'd0, 32'd0, 5'd5);
    send(6'd8, 32'd0, 32'd0, 5'd6);
    in_valid = 1'b0;
    tick(10);
    check("mult_wb_count", 64'(wb_cycs.size() - n0), 64'(2));
    if (wb_cycs.size() >= n0 + 2) begin
      // wb seen 1 edge after mfhi issue; mult issue edge is one past its sighting.
      check("mfhi_issue_gap", 64'(wb_cycs[n0] - mult_cyc), 64'(5));
      check("mflo_follow", 64'(wb_cycs[n0+1] - wb_cycs[n0]), 64'(1));
    end

    n0 = wb_cycs.size();
    sb.push_back({5'd12, 32'd0});
    sb.push_back({5'd13, 32'd63});
    sb.push_back({5'd14, 32'h00000010});
    send(6'd4, 32'd7, 32'd9, 5'd0);
    send(6'd7, 32'd0, 32'd0, 5'd12);
    send(6'd8, 32'd0, 32'd0, 5'd13);
    in_op = 6'd2;
    in_a0 = 32'h100;
    in_a1 = 32'd4;
    in_dst = 5'd14;
    @(negedge clk);
    check("stall_in_ready_full", 64'(in_ready), 64'(0));
    send(6'd2, 32'h100, 32'd4, 5'd14);
    in_valid = 1'b0;
    tick(10);
    check("stall_wb_count", 64'(wb_cycs.size() - n0), 64'(3));

    n0 = wb_cycs.size();
    sb.push_back({5'd20, 32'h0000000F});
    send(6'd2, 32'h000000F0, 32'd4, 5'd20);
    send(6'd3, 32'h80000000, 32'd4, 5'd21);
    in_op = 6'd2;
    in_dst = 5'd22;
    flush = 1'b1;
    @(negedge clk);
    check("flush_alu_op", 64'(alu_op), 64'(0));
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'(1));
    check("flush_alu_a0_empty", 64'(alu_a0), 64'(0));
    tick(6);
    check("flush_wb_count", 64'(wb_cycs.size() - n0), 64'(1));

    n0 = wb_cycs.size();
    sb.push_back({5'd1, 32'h12345678});
    send(6'd5, 32'h12345678, 32'd0, 5'd0);
    send(6'd7, 32'd0, 32'd0, 5'd1);
    in_valid = 1'b0;
    tick(8);
    check("mthi_wb_count", 64'(wb_cycs.size() - n0), 64'(1));
    n0 = wb_cycs.size();
    send(6'd9, 32'hAAAA, 32'hBBBB, 5'd2);
    in_valid = 1'b0;
    @(negedge clk);
    check("op9_alu_op", 64'(alu_op), 64'(0));
    tick(5);
    check("op9_no_wb", 64'(wb_cycs.size() - n0), 64'(0));
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
